float_mul_arbiter: RTL and testbench
====================================

Name: float_mul_arbiter

Overview:
- Shares one single-precision float multiplier core between N_REQ requesters. Typical requesters: the gain-adjust, drift-correction and power-calculation sequencers of the BPM processing chain.
- Round-robin arbitration. At most one operation is in flight at a time.
- Drives the core's operation_nd/operation_rfd/rdy handshake and routes each result back to the requester that issued it.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- SF_WIDTH, 32, float operand/result width
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MUL_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request; held high with operands stable until req_ack
- req_a  in  N_REQ*SF_WIDTH  operand A, requester i at bits [i*SF_WIDTH +: SF_WIDTH]
- req_b  in  N_REQ*SF_WIDTH  operand B, same packing as req_a
- req_ack  out  N_REQ  one-hot, 1-cycle pulse: operands accepted
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse: rsp_data belongs to requester i
- rsp_data  out  SF_WIDTH  product, held until the next response
- mul_a  out  SF_WIDTH  to core input a
- mul_b  out  SF_WIDTH  to core input b
- mul_nd  out  1  to core operation_nd; 1-cycle pulse
- mul_rfd  in  1  from core operation_rfd
- mul_result  in  SF_WIDTH  from core result
- mul_rdy  in  1  from core rdy
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: state IDLE, rr_ptr 0, grant index 0, all outputs 0 (req_ack, rsp_valid, rsp_data, mul_a, mul_b, mul_nd, busy, timeout_err).
- Reset mid-operation:
  - Returns to IDLE immediately.
  - No ack or response is produced for the aborted operation.
  - A late mul_rdy from the core is ignored, because mul_rdy is sampled only in WAIT.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from rr_ptr with wrap-around.
  - Register the grant index; go to ISSUE.
  - mul_rdy is ignored.
- ISSUE:
  - If req_valid[grant] has dropped: return to IDLE with no ack, no nd, rr_ptr unchanged.
  - Else, if mul_rfd=1:
    - register mul_a/mul_b from the granted slice;
    - mul_nd<=1 and req_ack[grant]<=1;
    - rr_ptr <= (grant+1) mod N_REQ;
    - go to WAIT.
  - Else (mul_rfd=0): stay in ISSUE, no pulses.
- WAIT:
  - mul_nd and req_ack return to 0 on the first WAIT cycle.
  - When mul_rdy=1: rsp_data<=mul_result, rsp_valid[grant]<=1 for one cycle, go to IDLE.
  - rsp_valid clears on the following cycle.
- Minimum latency, with rfd high and core latency L: req_valid seen in IDLE at cycle 0; ack/nd visible at cycle 2; rsp_valid visible at cycle 2+L+1.
- Simultaneous events:
  - New req_valid bits arriving during ISSUE/WAIT are held off and arbitrated in the next IDLE.
  - A requester may re-request in the cycle after its rsp_valid.
- No arithmetic is performed on operands; they pass through bit-exact.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without mul_rdy.
  - If it reaches TIMEOUT_CYCLES: rsp_data<=32'h7FC00000 (quiet NaN), rsp_valid[grant] pulses, timeout_err<=1 (sticky until rst), state goes to IDLE.
  - If mul_rdy and the limit occur in the same cycle, mul_rdy wins.
- Not defined: WAIT holds indefinitely, timeout_err is tied 0, no counter logic is present.

Test Plan:
- Single request: req 1 with a=0x40000000 (2.0), b=0x40400000 (3.0), core model latency 6 -> mul_nd with mul_a/mul_b matching; req_ack[1] and rsp_valid[1] pulse once; rsp_data=0x40C00000 (6.0).
- Fairness:
  - All four req_valid high continuously from reset -> grant order 0,1,2,3,0,1.
  - Exactly one req_ack per rsp_valid; no second mul_nd before the prior mul_rdy.
- Backpressure: req 2 pending, mul_rfd held low for 10 cycles -> stays in ISSUE, mul_nd=0, req_ack=0; issue occurs the cycle after mul_rfd rises.
- Withdrawal: req 3 dropped in ISSUE while mul_rfd=0 -> no ack/nd; next IDLE grants req 0 if it is pending; rr_ptr unchanged.
- Reset in WAIT: rst for 1 cycle, then the core asserts mul_rdy -> no rsp_valid; busy=0; next request is granted starting from requester 0.
- With MUL_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never raises mul_rdy -> rsp_valid pulses after 16 WAIT cycles; rsp_data=0x7FC00000; timeout_err stays 1 until rst.

Source files
------------

// File: rtl/float_mul_arbiter_if.sv
// Bundle of the requester-side and multiplier-core-side signals of
// float_mul_arbiter. The arbiter uses the slave modport; the requesters
// and the core model sit on the master modport.
interface float_mul_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int SF_WIDTH = 32
);
  // Requester side
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*SF_WIDTH-1:0] req_a;
  logic [N_REQ*SF_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]          req_ack;
  logic [N_REQ-1:0]          rsp_valid;
  logic [SF_WIDTH-1:0]       rsp_data;

  // Multiplier core side
  logic [SF_WIDTH-1:0]       mul_a;
  logic [SF_WIDTH-1:0]       mul_b;
  logic                      mul_nd;
  logic                      mul_rfd;
  logic [SF_WIDTH-1:0]       mul_result;
  logic                      mul_rdy;

  modport slave (
    input  req_valid, req_a, req_b, mul_rfd, mul_result, mul_rdy,
    output req_ack, rsp_valid, rsp_data, mul_a, mul_b, mul_nd
  );

  modport master (
    output req_valid, req_a, req_b, mul_rfd, mul_result, mul_rdy,
    input  req_ack, rsp_valid, rsp_data, mul_a, mul_b, mul_nd
  );
endinterface

// File: rtl/float_mul_arbiter.sv
// float_mul_arbiter: shares one single-precision float multiplier core
// between N_REQ requesters with round-robin arbitration and at most one
// operation in flight. Operands and results pass through bit-exact; the
// result is routed back to the requester that issued the operation.
//
// Optional feature: define MUL_TIMEOUT_EN to add a WAIT-state watchdog.
// After TIMEOUT_CYCLES WAIT cycles without mul_rdy the arbiter answers the
// granted requester with a quiet NaN and sets the sticky timeout_err flag.
// Without the macro WAIT holds indefinitely and timeout_err is tied low.
module float_mul_arbiter #(
  parameter int N_REQ          = 4,
  parameter int SF_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  float_mul_arbiter_if.slave bus,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Reject configurations outside the supported range at elaboration time.
  generate
    if (N_REQ < 2 || N_REQ > 8 || SF_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : gParamCheck
      $error("float_mul_arbiter: parameter out of supported range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   grantIdx;
  logic [IDX_W-1:0]   nextGrant;
  logic [SF_WIDTH-1:0] grantA;
  logic [SF_WIDTH-1:0] grantB;
  logic               grantStillValid;

  // First requester with valid set, searching upward from ptr with wrap.
  function automatic logic [IDX_W-1:0] rrPick(input logic [N_REQ-1:0] v,
                                              input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] r;
    logic             found;
    int               j;
    r     = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && v[j[IDX_W-1:0]]) begin
        r     = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Wrap-around successor of a requester index.
  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  assign nextGrant       = rrPick(bus.req_valid, rrPtr);
  assign grantA          = bus.req_a[int'(grantIdx)*SF_WIDTH +: SF_WIDTH];
  assign grantB          = bus.req_b[int'(grantIdx)*SF_WIDTH +: SF_WIDTH];
  assign grantStillValid = bus.req_valid[grantIdx];
  assign busy            = (state != IDLE);

`ifdef MUL_TIMEOUT_EN
  localparam int                  CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SF_WIDTH-1:0] QNAN     = SF_WIDTH'(32'h7FC00000);

  logic [CNT_W-1:0] waitCnt;
  logic             timeoutFlag;

  assign timeout_err = timeoutFlag;
`else
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, hand operands to the core in ISSUE,
  // wait for the core result in WAIT and route it back to the grantee.
  // Pulse outputs default low every cycle and are raised for one cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rrPtr         <= '0;
      grantIdx      <= '0;
      bus.req_ack   <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.mul_nd    <= 1'b0;
`ifdef MUL_TIMEOUT_EN
      waitCnt       <= '0;
      timeoutFlag   <= 1'b0;
`endif
    end else begin
      bus.req_ack   <= '0;
      bus.rsp_valid <= '0;
      bus.mul_nd    <= 1'b0;

      unique case (state)
        IDLE: begin
          // mul_rdy is deliberately not looked at here: a result arriving
          // after a reset abort must not be reported to anyone.
          if (|bus.req_valid) begin
            grantIdx <= nextGrant;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          if (!grantStillValid) begin
            // Requester withdrew before acceptance; pointer stays put so the
            // search resumes from the same place.
            state <= IDLE;
          end else if (bus.mul_rfd) begin
            bus.mul_a             <= grantA;
            bus.mul_b             <= grantB;
            bus.mul_nd            <= 1'b1;
            bus.req_ack[grantIdx] <= 1'b1;
            rrPtr                 <= nextIdx(grantIdx);
            state                 <= WAIT;
`ifdef MUL_TIMEOUT_EN
            waitCnt               <= '0;
`endif
          end
        end

        WAIT: begin
          if (bus.mul_rdy) begin
            bus.rsp_data            <= bus.mul_result;
            bus.rsp_valid[grantIdx] <= 1'b1;
            state                   <= IDLE;
          end
`ifdef MUL_TIMEOUT_EN
          else if (waitCnt == CNT_LAST) begin
            // Core never answered: release the requester with a quiet NaN.
            bus.rsp_data            <= QNAN;
            bus.rsp_valid[grantIdx] <= 1'b1;
            timeoutFlag             <= 1'b1;
            state                   <= IDLE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Self-checking bench for float_mul_arbiter: directed scenarios followed by
// randomized traffic. A behavioural core model answers mul_nd after a
// programmable latency; a reference model predicts grants from the
// round-robin rule and pushes expected responses into a scoreboard queue
// that an independent negedge monitor drains.
module tb_float_mul_arbiter;

  localparam int N_REQ          = 4;
  localparam int SF_WIDTH       = 32;
  localparam int TIMEOUT_CYCLES = 16;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic timeout_err;

  float_mul_arbiter_if #(.N_REQ(N_REQ), .SF_WIDTH(SF_WIDTH)) bus ();

  float_mul_arbiter #(
    .N_REQ(N_REQ), .SF_WIDTH(SF_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in for the float core: exact for the 2.0*3.0 case, otherwise a
  // mixing function so that routing errors show up as data errors.
  function automatic logic [31:0] coreFn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]};
  endfunction

  function automatic int rrChoose(input logic [N_REQ-1:0] v, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (ptr + k) % N_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Requester-side state
  logic [31:0] opA [N_REQ];
  logic [31:0] opB [N_REQ];
  logic [31:0] ackA[N_REQ];
  logic [31:0] ackB[N_REQ];
  bit keepAlive = 0;
  bit randMode  = 0;

  // Core model control
  bit coreNever   = 0;
  bit coreRandLat = 0;
  int coreLat     = 6;
  int coreCnt     = 0;
  logic [31:0] coreRes;

  // Reference model / scoreboard
  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          isTimeout;
    int          ackCyc;
  } rsp_t;
  rsp_t rspQ[$];
  int   gPend     = -1;
  bit   mFree     = 1;
  bit   mFreeNext = 0;
  int   mPtr      = 0;
  bit   inFlight  = 0;
  logic [31:0] lastRsp = '0;
  bit   expTe     = 0;

  int ackHist[$];
  int ackCount = 0, rspCount = 0;
  int lastAckCyc = -1, lastRspCyc = -1, lastRspIdx = -1;
  logic [31:0] lastRspData = '0;

  // Core model: answers each mul_nd after a latency, ignoring reset.
  initial begin
    bus.mul_rdy    = 1'b0;
    bus.mul_result = '0;
    forever begin
      @(posedge clk); #1;
      bus.mul_rdy    = 1'b0;
      bus.mul_result = $urandom;
      if (coreCnt > 0) begin
        coreCnt--;
        if (coreCnt == 0) begin
          bus.mul_rdy    = 1'b1;
          bus.mul_result = coreRes;
        end
      end
      if (bus.mul_nd && !coreNever) begin
        coreRes = coreFn(bus.mul_a, bus.mul_b);
        coreCnt = coreRandLat ? int'($urandom_range(1, 6)) : coreLat;
      end
    end
  end

  // Monitor: predicts grants, checks acks/issues, drains the scoreboard.
  always @(negedge clk) begin : monitor
    rsp_t e;
    bit   expBusy;
    int   g;
    if (rst) begin
      rspQ.delete();
      gPend = -1; mFree = 1; mFreeNext = 0; mPtr = 0;
      inFlight = 0; lastRsp = '0; expTe = 0;
    end else begin
      expBusy = ((gPend >= 0) || inFlight) && !(|bus.rsp_valid);
      if (mFreeNext) begin mFree = 1; mFreeNext = 0; end

      if (bus.mul_nd || (|bus.req_ack)) begin
        chk("ack_nd_pair", {62'd0, bus.mul_nd, $onehot(bus.req_ack)}, 64'd3);
        if ($onehot(bus.req_ack)) begin
          g = 0;
          for (int i = 0; i < N_REQ; i++) if (bus.req_ack[i]) g = i;
          chk("grant_order", g, gPend);
          chk("no_overlap", inFlight, 0);
          chk("mul_a", bus.mul_a, ackA[g]);
          chk("mul_b", bus.mul_b, ackB[g]);
`ifdef MUL_TIMEOUT_EN
          e.isTimeout = coreNever;
`else
          e.isTimeout = 0;
`endif
          e.idx    = g;
          e.data   = e.isTimeout ? QNAN : coreFn(ackA[g], ackB[g]);
          e.ackCyc = cyc;
          rspQ.push_back(e);
          inFlight = 1;
          mPtr     = (g + 1) % N_REQ;
          gPend    = -1;
          ackHist.push_back(g);
          ackCount++;
          lastAckCyc = cyc;
        end
      end else if (gPend >= 0 && !bus.req_valid[gPend]) begin
        gPend     = -1;
        mFreeNext = 1;
      end

      if (|bus.rsp_valid) begin
        rspCount++;
        if (rspQ.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          e = rspQ.pop_front();
          chk("rsp_idx", bus.rsp_valid, 64'd1 << e.idx);
          chk("rsp_data", bus.rsp_data, e.data);
          if (e.isTimeout) begin
            chk("timeout_latency", cyc - e.ackCyc, TIMEOUT_CYCLES);
            expTe = 1;
          end
          lastRsp = e.data;
          lastRspIdx = e.idx;
        end
        inFlight    = 0;
        mFree       = 1;
        lastRspCyc  = cyc;
        lastRspData = bus.rsp_data;
      end else begin
        chk("rsp_data_hold", bus.rsp_data, lastRsp);
      end

      chk("busy", busy, expBusy);
      chk("timeout_err", timeout_err, expTe);

      if (mFree && (|bus.req_valid)) begin
        gPend = rrChoose(bus.req_valid, mPtr);
        mFree = 0;
      end
    end
  end

  task automatic setOp(input int i, input logic [31:0] a, input logic [31:0] b);
    opA[i] = a;
    opB[i] = b;
    bus.req_a[i*SF_WIDTH +: SF_WIDTH] = a;
    bus.req_b[i*SF_WIDTH +: SF_WIDTH] = b;
  endtask

  // One clock of requester behaviour, applied just after the rising edge.
  task automatic tick();
    bit acked[N_REQ];
    @(posedge clk); #1;
    for (int i = 0; i < N_REQ; i++) begin
      acked[i] = bus.req_ack[i];
      if (acked[i]) begin
        ackA[i] = opA[i];
        ackB[i] = opB[i];
        if (keepAlive) setOp(i, $urandom, $urandom);
        else bus.req_valid[i] = 1'b0;
      end
    end
    if (randMode) begin
      for (int i = 0; i < N_REQ; i++)
        if (!acked[i] && !bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          setOp(i, $urandom, $urandom);
          bus.req_valid[i] = 1'b1;
        end
      bus.mul_rfd = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    chk("reset_ctrl", {bus.req_ack, bus.rsp_valid, bus.mul_nd, busy, timeout_err}, 0);
    chk("reset_data", {bus.rsp_data, bus.mul_a}, 0);
    chk("reset_mul_b", bus.mul_b, 0);
    rst = 1'b0;
  endtask

  task automatic waitAck(input int target, input int maxc, input string nm);
    int k = 0;
    while (ackCount < target && k < maxc) begin tick(); k++; end
    chk(nm, ackCount >= target, 1);
  endtask

  task automatic waitRsp(input int target, input int maxc, input string nm);
    int k = 0;
    while (rspCount < target && k < maxc) begin tick(); k++; end
    chk(nm, rspCount >= target, 1);
  endtask

  task automatic waitIdle(input int maxc, input string nm);
    int k = 0;
    while ((busy || bus.req_valid != 0 || rspQ.size() != 0) && k < maxc) begin tick(); k++; end
    chk(nm, {busy, bus.req_valid != 0, rspQ.size() != 0}, 0);
  endtask

  int expOrder[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int c0, a0, r0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.mul_rfd   = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      opA[i] = '0; opB[i] = '0; ackA[i] = '0; ackB[i] = '0;
    end
    doReset(3);

    // Single request: 2.0 * 3.0 from requester 1, core latency 6
    coreLat = 6;
    tick();
    setOp(1, 32'h40000000, 32'h40400000);
    bus.req_valid[1] = 1'b1;
    c0 = cyc; a0 = ackCount; r0 = rspCount;
    waitRsp(r0 + 1, 40, "single_wait");
    chk("single_ack_lat", lastAckCyc - c0, 2);
    chk("single_rsp_lat", lastRspCyc - c0, 9);
    chk("single_ack_cnt", ackCount - a0, 1);
    chk("single_rsp_idx", lastRspIdx, 1);
    chk("single_rsp_data", lastRspData, 32'h40C00000);
    waitIdle(20, "single_idle");

    // Fairness: all four held high continuously from reset
    for (int i = 0; i < N_REQ; i++) setOp(i, $urandom, $urandom);
    bus.req_valid = '1;
    keepAlive = 1;
    doReset(2);
    ackHist.delete();
    a0 = ackCount; r0 = rspCount;
    waitAck(a0 + 6, 200, "fair_wait");
    keepAlive = 0;
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++)
      chk("fair_order", (ackHist.size() > k) ? ackHist[k] : -1, expOrder[k]);
    waitIdle(40, "fair_idle");
    chk("fair_ack_per_rsp", ackCount - a0, rspCount - r0);

    // Backpressure: requester 2 with mul_rfd low for 10 cycles
    bus.mul_rfd = 1'b0;
    setOp(2, $urandom, $urandom);
    bus.req_valid[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold", {bus.req_ack, bus.mul_nd}, 0);
    end
    chk("bp_busy", busy, 1);
    bus.mul_rfd = 1'b1;
    tick();
    chk("bp_issue", {bus.req_ack, bus.mul_nd}, {4'b0100, 1'b1});
    waitIdle(40, "bp_idle");

    // Withdrawal: requester 3 granted then dropped while mul_rfd is low
    bus.mul_rfd = 1'b0;
    setOp(3, $urandom, $urandom);
    setOp(0, $urandom, $urandom);
    bus.req_valid[3] = 1'b1;
    bus.req_valid[0] = 1'b1;
    a0 = ackCount;
    tick();
    bus.req_valid[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wd_no_ack", {bus.req_ack, bus.mul_nd}, 0);
    end
    bus.mul_rfd = 1'b1;
    waitAck(a0 + 1, 20, "wd_wait");
    chk("wd_grant", ackHist[$], 0);
    waitIdle(40, "wd_idle");

    // Reset while waiting on the core; the core still answers afterwards
    setOp(1, $urandom, $urandom);
    bus.req_valid[1] = 1'b1;
    waitAck(ackCount + 1, 20, "rw_wait");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0 = rspCount;
    repeat (12) tick();
    chk("rw_no_rsp", rspCount - r0, 0);
    chk("rw_busy", busy, 0);
    chk("rw_rsp_data", bus.rsp_data, 0);
    setOp(2, $urandom, $urandom);
    setOp(0, $urandom, $urandom);
    bus.req_valid[2] = 1'b1;
    bus.req_valid[0] = 1'b1;
    waitAck(ackCount + 1, 20, "rw_regrant");
    chk("rw_grant_from0", ackHist[$], 0);
    waitIdle(60, "rw_idle");

`ifdef MUL_TIMEOUT_EN
    // Core never answers: watchdog produces a quiet NaN
    coreNever = 1;
    setOp(0, $urandom, $urandom);
    bus.req_valid[0] = 1'b1;
    r0 = rspCount;
    waitRsp(r0 + 1, 60, "to_wait");
    coreNever = 0;
    chk("to_data", lastRspData, QNAN);
    chk("to_flag", timeout_err, 1);
    setOp(1, $urandom, $urandom);
    bus.req_valid[1] = 1'b1;
    waitRsp(rspCount + 1, 40, "to_next");
    chk("to_sticky", timeout_err, 1);
    doReset(1);
`else
    // Core never answers: WAIT holds, no response, no error flag
    coreNever = 1;
    setOp(0, $urandom, $urandom);
    bus.req_valid[0] = 1'b1;
    r0 = rspCount;
    waitAck(ackCount + 1, 20, "hold_wait");
    repeat (40) tick();
    chk("hold_busy", busy, 1);
    chk("hold_no_rsp", rspCount - r0, 0);
    chk("hold_no_err", timeout_err, 0);
    coreNever = 0;
    doReset(1);
`endif

    // Randomized traffic
    a0 = ackCount; r0 = rspCount;
    coreRandLat = 1;
    randMode    = 1;
    repeat (2000) tick();
    randMode    = 0;
    bus.mul_rfd = 1'b1;
    waitIdle(300, "rand_drain");
    chk("rand_ack_per_rsp", ackCount - a0, rspCount - r0);
    chk("rand_activity", (ackCount - a0) > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
